strbuf_responder: RTL
=====================

Name: strbuf_responder

Overview:
- Store-buffer-side responder for the prefetcher's dual-lane store-buffer interface.
- Services the prefetcher's two-address read requests through the req/wait/data_ready handshake.
- Accepts up to two word writes per cycle into a local word array.
- Sits between the prefetcher top and the store-buffer memory; replaces the bench model of the store buffer.

Parameters:
- DEPTH, 64: number of 32-bit words held. Power of two, 2..1024.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be 4*DEPTH aligned.
- READ_LAT, 3: cycles from request-accept edge to data_ready pulse. Range 1..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- strBuf_data_req  in  1  read request; single-cycle pulse.
- strBuf_r_addr  in  32 x2 (unpacked [1:0])  byte read address per lane.
- strBufWren  in  1 x2  write enable per lane.
- w_addr  in  32 x2  byte write address per lane.
- w_data  in  32 x2  write data per lane.
- wait_strBuf  out  1  responder busy; request not accepted.
- strBuf_data_ready  out  1  one-cycle pulse; strBuf_data valid.
- strBuf_data  out  32 x2  read data per lane; holds until next response.
- addr_err  out  1  sticky flag: an out-of-range address was seen.

Behaviour:
- Address map:
  - In range iff BASE_ADDR <= a < BASE_ADDR + 4*DEPTH.
  - Word index = (a - BASE_ADDR) >> 2; bits [1:0] ignored.
- Reset (sampled at edge):
  - FSM -> IDLE; wait_strBuf=0, strBuf_data_ready=0, strBuf_data[0..1]=0, addr_err=0.
  - All DEPTH words cleared to 0.
  - Any in-flight request is abandoned; no data_ready pulse follows.
  - Writes presented in the reset cycle are dropped.
- Writes:
  - Accepted every cycle regardless of FSM state. Commit at the edge.
  - Out-of-range write is dropped and sets addr_err.
  - Both lanes to the same word in one cycle: lane 1 wins.
- FSM: IDLE, BUSY, RESP.
  - IDLE:
    - strBuf_data_req=1 at edge E0 accepts the request.
    - Both lanes are read at E0 and the values are captured into the response pipeline.
    - -> RESP if READ_LAT=1, else -> BUSY with counter=READ_LAT-1.
  - BUSY:
    - wait_strBuf=1; counter decrements each edge.
    - -> RESP when counter reaches 1 at an edge.
  - RESP:
    - strBuf_data_ready=1 and wait_strBuf=0 for exactly one cycle. Always -> IDLE.
- Latency: data_ready is high in the cycle following edge E0+(READ_LAT-1) edges.
  - READ_LAT=1: ready in the cycle right after E0; wait never rises.
  - READ_LAT=3: wait is high for 2 cycles, then ready.
- Read data snapshot: reflects all writes committed at edges before E0, plus writes presented in the cycle ending at E0.
  - Same-cycle writes are forwarded; lane-1 priority applies.
  - Writes after E0 do not affect the response.
- Out-of-range read lane returns 32'h0 and sets addr_err. The other lane is unaffected.
- Both read lanes may target the same word.
- strBuf_data_req while in BUSY or RESP is ignored (no queueing). The initiator must hold off while wait_strBuf=1 or data_ready=1.
- strBuf_data is updated only on the RESP entry edge and is stable otherwise.
- addr_err is cleared only by reset.

Test Plan:
- Reset then read: reset; req with addrs 0x0,0x4 -> ready after READ_LAT; data 0,0; wait=1 exactly 2 cycles with READ_LAT=3.
- Write then read: write lane0 0x8<=0xDEADBEEF, lane1 0xC<=0x12345678; next cycle req 0x8,0xC -> data 0xDEADBEEF, 0x12345678.
- Forwarding and priority: same cycle as req, both lanes write 0x10 (lane0 0x1111, lane1 0x2222); req reads 0x10,0x10 -> both lanes 0x2222.
- Snapshot: req at 0x20 (holding 5); write 0x20<=9 during BUSY -> response 5; next req -> 9.
- Ignored request and range check: second req during BUSY -> exactly one ready pulse. Read 4*DEPTH+BASE -> lane 0x0 and addr_err=1 (sticky until reset).
- Reset mid-op: req, then reset in first BUSY cycle -> no ready pulse; wait=0; data=0; memory zeroed.

Source files
------------

// File: rtl/strbuf_responder.sv
// Store-buffer-side responder: dual-lane word array with per-cycle writes and a
// fixed-latency two-address read handshake (req / wait / data_ready).
module strbuf_responder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          READ_LAT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strBuf_data_req,
    input  logic [31:0] strBuf_r_addr [1:0],
    input  logic        strBufWren    [1:0],
    input  logic [31:0] w_addr        [1:0],
    input  logic [31:0] w_data        [1:0],
    output logic        wait_strBuf,
    output logic        strBuf_data_ready,
    output logic [31:0] strBuf_data   [1:0],
    output logic        addr_err
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN = 33'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        wait_q, wait_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] snap_q [1:0];
    logic [31:0] snap_d [1:0];
    logic [31:0] data_q [1:0];
    logic [31:0] data_d [1:0];
    logic [31:0] mem_q  [DEPTH];
    logic [31:0] mem_d  [DEPTH];

    logic [31:0] w_off  [1:0];
    logic [31:0] r_off  [1:0];
    logic        w_in   [1:0];
    logic        r_in   [1:0];
    logic [31:0] rd_val [1:0];

    // An address below BASE_ADDR wraps to a huge offset, so one compare covers both bounds.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_off[i] = w_addr[i] - BASE_ADDR;
            r_off[i] = strBuf_r_addr[i] - BASE_ADDR;
            w_in[i]  = {1'b0, w_off[i]} < SPAN;
            r_in[i]  = {1'b0, r_off[i]} < SPAN;
        end
    end

    // Reads sample the post-write array so same-cycle writes forward, lane 1 last.
    always_comb begin
        mem_d = mem_q;
        err_d = err_q;
        for (int i = 0; i < 2; i++) begin
            if (strBufWren[i]) begin
                if (w_in[i]) mem_d[w_off[i][AW+1:2]] = w_data[i];
                else         err_d = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            rd_val[i] = r_in[i] ? mem_d[r_off[i][AW+1:2]] : 32'h0;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = 1'b0;
        ready_d = 1'b0;
        snap_d  = snap_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (strBuf_data_req) begin
                    for (int i = 0; i < 2; i++) begin
                        snap_d[i] = rd_val[i];
                        if (!r_in[i]) err_d = 1'b1;
                    end
                    if (READ_LAT == 1) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        data_d  = rd_val;
                    end else begin
                        state_d = BUSY;
                        wait_d  = 1'b1;
                        cnt_d   = 5'(READ_LAT - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 5'd1) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    data_d  = snap_q;
                end else begin
                    cnt_d  = cnt_q - 5'd1;
                    wait_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                snap_q[i] <= '0;
                data_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            for (int i = 0; i < 2; i++) begin
                snap_q[i] <= snap_d[i];
                data_q[i] <= data_d[i];
            end
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign wait_strBuf       = wait_q;
    assign strBuf_data_ready = ready_q;
    assign strBuf_data[0]    = data_q[0];
    assign strBuf_data[1]    = data_q[1];
    assign addr_err          = err_q;

endmodule
